// File: rtl/mux_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux_arb_pkg
//   Shared types and defaults for the two-requester round-robin mux arbiter.
//   Contents:
//     arb_state_t    - arbiter FSM state (IDLE, GRANT0, GRANT1)
//     DEF_WIDTH      - default data width
//     DEF_BURST_LEN  - default maximum beats per grant before forced rotation
//     grant_of()     - maps a requester index to its grant state
// ---------------------------------------------------------------------------
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_BURST_LEN = 4;

  function automatic arb_state_t grant_of(input logic idx);
    return idx ? GRANT1 : GRANT0;
  endfunction

endpackage

// File: rtl/mux_2x1_bus.sv
// ---------------------------------------------------------------------------
// mux_2x1_bus
//   Purely combinational WIDTH-bit 2:1 select.
//   Ports:
//     s_i   in  1      select: 0 = i0_i, 1 = i1_i
//     i0_i  in  WIDTH  input word 0
//     i1_i  in  WIDTH  input word 1
//     y_o   out WIDTH  selected word
// ---------------------------------------------------------------------------
module mux_2x1_bus #(
  parameter int WIDTH = 8
) (
  input  logic             s_i,
  input  logic [WIDTH-1:0] i0_i,
  input  logic [WIDTH-1:0] i1_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = s_i ? i1_i : i0_i;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux2_rr_arbiter
//   Round-robin arbiter sharing one 2:1 datapath between two requesters, with
//   a per-grant burst limit and a registered valid/ready output slot.
//   Ports:
//     clk      in   1      rising-edge clock
//     rst      in   1      synchronous, active-high reset
//     req0/i0  in   1/W    requester 0 request and data (held until taken)
//     req1/i1  in   1/W    requester 1 request and data (held until taken)
//     lock0/1  in   1      (ARB_LOCK_EN only) owner lock, suppresses rotation
//     gnt0/1   out  1      requester owns the datapath
//     take0/1  out  1      combinational strobe: word consumed this cycle
//     s        out  1      registered mux select, equals gnt1
//     Q        out  W      registered output word
//     q_valid  out  1      Q holds a valid word
//     q_ready  in   1      consumer accepts Q when q_valid && q_ready
//   Build option: define ARB_LOCK_EN to add the lock0/lock1 ports.
// ---------------------------------------------------------------------------
module mux2_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] i0,
  input  logic             req1,
  input  logic [WIDTH-1:0] i1,
`ifdef ARB_LOCK_EN
  input  logic             lock0,
  input  logic             lock1,
`endif
  output logic             gnt0,
  output logic             gnt1,
  output logic             take0,
  output logic             take1,
  output logic             s,
  output logic [WIDTH-1:0] Q,
  output logic             q_valid,
  input  logic             q_ready
);

  localparam int               CNT_W   = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             last_q, last_d;
  logic             s_q;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_valid_q, q_valid_d;

  logic [WIDTH-1:0] mux_y;
  logic             owner;
  logic             owner_req;
  logic             other_req;
  logic             owner_lock;
  logic             slot_free;
  logic             take;
  logic             burst_done;

  mux_2x1_bus #(.WIDTH(WIDTH)) u_mux (
    .s_i  (s_q),
    .i0_i (i0),
    .i1_i (i1),
    .y_o  (mux_y)
  );

  // Index of the current owner; only meaningful in the GRANT states.
  assign owner     = (state_q == GRANT1);
  assign owner_req = owner ? req1 : req0;
  assign other_req = owner ? req0 : req1;

`ifdef ARB_LOCK_EN
  assign owner_lock = owner ? lock1 : lock0;
`else
  assign owner_lock = 1'b0;
`endif

  assign slot_free = !q_valid_q || q_ready;
  assign take0     = (state_q == GRANT0) && req0 && slot_free;
  assign take1     = (state_q == GRANT1) && req1 && slot_free;
  assign take      = take0 || take1;

  // True when the current take is the last beat allowed in this grant. The
  // ">=" also covers a count saturated at BURST_LEN while locked, so the first
  // take after the lock drops rotates immediately.
  assign burst_done = (beat_cnt_q >= (CNT_MAX - CNT_ONE));

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    last_d     = last_q;
    q_d        = q_q;
    q_valid_d  = q_valid_q;

    unique case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d = grant_of(!last_q);
        end else if (req0) begin
          state_d = GRANT0;
        end else if (req1) begin
          state_d = GRANT1;
        end
      end

      GRANT0, GRANT1: begin
        if (!owner_req) begin
          state_d    = other_req ? grant_of(!owner) : IDLE;
          beat_cnt_d = '0;
        end else if (take) begin
          if (!burst_done) begin
            beat_cnt_d = beat_cnt_q + CNT_ONE;
          end else if (owner_lock) begin
            beat_cnt_d = CNT_MAX;
          end else begin
            beat_cnt_d = '0;
            if (other_req) begin
              state_d = grant_of(!owner);
            end
          end
        end
        // Stalled (owner requesting, slot busy): hold everything.
      end

      default: state_d = IDLE;
    endcase

    // Output slot: a take always loads the slot; it is only legal when the
    // slot is free, so a word the consumer has not accepted is never lost.
    if (take) begin
      q_d       = mux_y;
      q_valid_d = 1'b1;
      last_d    = owner;
    end else if (q_valid_q && q_ready) begin
      q_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      last_q     <= 1'b1;
      s_q        <= 1'b0;
      q_q        <= '0;
      q_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      last_q     <= last_d;
      // Select follows the next state so it only moves on grant changes.
      s_q        <= (state_d == GRANT1);
      q_q        <= q_d;
      q_valid_q  <= q_valid_d;
    end
  end

  assign gnt0    = (state_q == GRANT0);
  assign gnt1    = (state_q == GRANT1);
  assign s       = s_q;
  assign Q       = q_q;
  assign q_valid = q_valid_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux2_rr_arbiter
//   Bench for mux2_rr_arbiter (WIDTH=8, BURST_LEN=4): a cycle table for the
//   single-beat, drop-out and stall behaviour, a scoreboard for burst
//   rotation, and hand sequences for reset corners.
// ---------------------------------------------------------------------------
module tb_mux2_rr_arbiter;

  logic       clk;
  logic       rst;
  logic       req0, req1;
  logic [7:0] i0, i1;
  logic       gnt0, gnt1, take0, take1, s;
  logic [7:0] Q;
  logic       q_valid, q_ready;
`ifdef ARB_LOCK_EN
  logic       lock0, lock1;
`endif

  mux2_rr_arbiter #(.WIDTH(8), .BURST_LEN(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .i0      (i0),
    .req1    (req1),
    .i1      (i1),
`ifdef ARB_LOCK_EN
    .lock0   (lock0),
    .lock1   (lock1),
`endif
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .take0   (take0),
    .take1   (take1),
    .s       (s),
    .Q       (Q),
    .q_valid (q_valid),
    .q_ready (q_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- cycle table ----------------
  typedef struct {
    logic       req0;
    logic [7:0] i0;
    logic       req1;
    logic [7:0] i1;
    logic       rdy;
    logic       gnt0, gnt1, take0, take1, s, qv;
    logic [7:0] q;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs[NVEC];

  function automatic vec_t mk(input logic r0, input logic [7:0] d0, input logic r1,
                              input logic [7:0] d1, input logic rdy,
                              input logic g0, input logic g1, input logic t0, input logic t1,
                              input logic sel, input logic qv, input logic [7:0] q);
    vec_t v;
    v.req0 = r0; v.i0 = d0; v.req1 = r1; v.i1 = d1; v.rdy = rdy;
    v.gnt0 = g0; v.gnt1 = g1; v.take0 = t0; v.take1 = t1; v.s = sel; v.qv = qv; v.q = q;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  logic [7:0] src0[$];
  logic [7:0] src1[$];
  bit         exp_owner_q[$];
  logic [7:0] exp_data_q[$];
  bit         sb_on        = 1'b0;
  bit         auto_src     = 1'b0;
  bit         random_ready = 1'b0;
  int         take0_cnt    = 0;
`ifdef ARB_LOCK_EN
  int         lock_release = 0;
`endif

  task automatic drive_src();
    req0 = (src0.size() != 0);
    i0   = req0 ? src0[0] : 8'h00;
    req1 = (src1.size() != 0);
    i1   = req1 ? src1[0] : 8'h00;
  endtask

  // One clock: monitor at the falling edge, update producers after the rise.
  task automatic step();
    logic t0, t1;
    bit   eo;
    @(negedge clk);
    t0 = take0;
    t1 = take1;
    if (sb_on) begin
      if (t0 || t1) begin
        if (exp_owner_q.size() == 0) begin
          check("take_extra", 32'd1, 32'd0);
        end else begin
          eo = exp_owner_q.pop_front();
          check("take_owner", {30'd0, t1, t0}, eo ? 32'd2 : 32'd1);
          check("s_owner", {31'd0, s}, {31'd0, eo});
        end
      end
      if (q_valid && q_ready) begin
        if (exp_data_q.size() == 0) check("q_extra", 32'd1, 32'd0);
        else check("q_data", {24'd0, Q}, {24'd0, exp_data_q.pop_front()});
      end
    end
    @(posedge clk);
    #1;
    if (auto_src) begin
      if (t0 && src0.size() != 0) void'(src0.pop_front());
      if (t1 && src1.size() != 0) void'(src1.pop_front());
      if (t0) take0_cnt++;
`ifdef ARB_LOCK_EN
      if (lock0 && take0_cnt == lock_release) lock0 = 1'b0;
`endif
      drive_src();
      if (random_ready) q_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic run_sb(input int max_cyc);
    int cyc;
    cyc       = 0;
    take0_cnt = 0;
    sb_on     = 1'b1;
    auto_src  = 1'b1;
    drive_src();
    while (exp_data_q.size() != 0 && cyc < max_cyc) begin
      step();
      cyc++;
    end
    check("sb_data_drained", exp_data_q.size(), 32'd0);
    check("sb_owner_drained", exp_owner_q.size(), 32'd0);
    sb_on    = 1'b0;
    auto_src = 1'b0;
    req0     = 1'b0;
    req1     = 1'b0;
  endtask

  // Both requesters hold 12 words; expect bursts of 4 alternating, i0 first.
  task automatic plan_rr();
    src0.delete(); src1.delete(); exp_owner_q.delete(); exp_data_q.delete();
    for (int k = 0; k < 12; k++) begin
      src0.push_back(8'h10 + 8'(k));
      src1.push_back(8'h80 + 8'(k));
    end
    for (int b = 0; b < 6; b++) begin
      for (int k = 0; k < 4; k++) begin
        exp_owner_q.push_back(bit'(b % 2));
        exp_data_q.push_back(((b % 2) == 1) ? 8'h80 + 8'(4 * (b / 2) + k)
                                            : 8'h10 + 8'(4 * (b / 2) + k));
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; i0 = 8'h00; i1 = 8'h00; q_ready = 1'b0;
`ifdef ARB_LOCK_EN
    lock0 = 1'b0; lock1 = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt0", {31'd0, gnt0}, 32'd0);
    check("rst_gnt1", {31'd0, gnt1}, 32'd0);
    check("rst_s", {31'd0, s}, 32'd0);
    check("rst_q_valid", {31'd0, q_valid}, 32'd0);
    check("rst_Q", {24'd0, Q}, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    // req0 i0 req1 i1 rdy | gnt0 gnt1 take0 take1 s qv Q
    vecs[0]  = mk(1, 8'hA5, 0, 8'h00, 1,  0, 0, 0, 0, 0, 0, 8'h00);
    vecs[1]  = mk(1, 8'hA5, 0, 8'h00, 1,  1, 0, 1, 0, 0, 0, 8'h00);
    vecs[2]  = mk(0, 8'h00, 0, 8'h00, 1,  1, 0, 0, 0, 0, 1, 8'hA5);
    vecs[3]  = mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 0, 0, 0, 8'hA5);
    vecs[4]  = mk(0, 8'h00, 1, 8'h11, 1,  0, 0, 0, 0, 0, 0, 8'hA5);
    vecs[5]  = mk(0, 8'h00, 1, 8'h11, 1,  0, 1, 0, 1, 1, 0, 8'hA5);
    vecs[6]  = mk(0, 8'h00, 1, 8'h22, 1,  0, 1, 0, 1, 1, 1, 8'h11);
    vecs[7]  = mk(0, 8'h00, 0, 8'h00, 1,  0, 1, 0, 0, 1, 1, 8'h22);
    vecs[8]  = mk(1, 8'h33, 1, 8'h44, 1,  0, 0, 0, 0, 0, 0, 8'h22);
    vecs[9]  = mk(1, 8'h33, 1, 8'h44, 1,  1, 0, 1, 0, 0, 0, 8'h22);
    vecs[10] = mk(0, 8'h00, 1, 8'h44, 1,  1, 0, 0, 0, 0, 1, 8'h33);
    vecs[11] = mk(0, 8'h00, 1, 8'h44, 1,  0, 1, 0, 1, 1, 0, 8'h33);
    vecs[12] = mk(0, 8'h00, 0, 8'h00, 1,  0, 1, 0, 0, 1, 1, 8'h44);
    vecs[13] = mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 0, 0, 0, 8'h44);
    vecs[14] = mk(1, 8'h55, 0, 8'h00, 0,  0, 0, 0, 0, 0, 0, 8'h44);
    vecs[15] = mk(1, 8'h55, 0, 8'h00, 0,  1, 0, 1, 0, 0, 0, 8'h44);
    vecs[16] = mk(1, 8'h66, 0, 8'h00, 0,  1, 0, 0, 0, 0, 1, 8'h55);
    vecs[17] = mk(1, 8'h66, 0, 8'h00, 0,  1, 0, 0, 0, 0, 1, 8'h55);
    vecs[18] = mk(1, 8'h66, 0, 8'h00, 0,  1, 0, 0, 0, 0, 1, 8'h55);
    vecs[19] = mk(1, 8'h66, 0, 8'h00, 1,  1, 0, 1, 0, 0, 1, 8'h55);
    vecs[20] = mk(0, 8'h00, 0, 8'h00, 1,  1, 0, 0, 0, 0, 1, 8'h66);
    vecs[21] = mk(0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 0, 0, 0, 8'h66);

    do_reset();

    // Single beat, requester-1 drop-out with tie afterwards, stall/resume.
    for (int v = 0; v < NVEC; v++) begin
      req0 = vecs[v].req0; i0 = vecs[v].i0;
      req1 = vecs[v].req1; i1 = vecs[v].i1;
      q_ready = vecs[v].rdy;
      @(negedge clk);
      check($sformatf("v%0d_gnt0", v),  {31'd0, gnt0},    {31'd0, vecs[v].gnt0});
      check($sformatf("v%0d_gnt1", v),  {31'd0, gnt1},    {31'd0, vecs[v].gnt1});
      check($sformatf("v%0d_take0", v), {31'd0, take0},   {31'd0, vecs[v].take0});
      check($sformatf("v%0d_take1", v), {31'd0, take1},   {31'd0, vecs[v].take1});
      check($sformatf("v%0d_s", v),     {31'd0, s},       {31'd0, vecs[v].s});
      check($sformatf("v%0d_qv", v),    {31'd0, q_valid}, {31'd0, vecs[v].qv});
      check($sformatf("v%0d_Q", v),     {24'd0, Q},       {24'd0, vecs[v].q});
      @(posedge clk);
      #1;
    end

    // Round-robin bursts with a consumer that is always ready.
    do_reset();
    q_ready = 1'b1;
    plan_rr();
    run_sb(200);

    // Same stream, consumer ready at random: order and rotation must hold.
    do_reset();
    q_ready = 1'b1;
    random_ready = 1'b1;
    plan_rr();
    run_sb(600);
    random_ready = 1'b0;

`ifdef ARB_LOCK_EN
    // lock0 held for 6 beats of i0, then released: i0 gets 7 beats (the
    // 7th rotates), then 4 from i1, then i0 finishes its remaining 3.
    do_reset();
    q_ready = 1'b1;
    src0.delete(); src1.delete(); exp_owner_q.delete(); exp_data_q.delete();
    for (int k = 0; k < 10; k++) src0.push_back(8'h20 + 8'(k));
    for (int k = 0; k < 4; k++)  src1.push_back(8'hC0 + 8'(k));
    for (int k = 0; k < 7; k++) begin exp_owner_q.push_back(1'b0); exp_data_q.push_back(8'h20 + 8'(k)); end
    for (int k = 0; k < 4; k++) begin exp_owner_q.push_back(1'b1); exp_data_q.push_back(8'hC0 + 8'(k)); end
    for (int k = 7; k < 10; k++) begin exp_owner_q.push_back(1'b0); exp_data_q.push_back(8'h20 + 8'(k)); end
    lock0 = 1'b1;
    lock_release = 6;
    run_sb(200);
    lock0 = 1'b0;
`endif

    // Reset mid-burst with a pending word, then a tie goes to requester 0.
    do_reset();
    req0 = 1'b1; i0 = 8'h77; q_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pend_q_valid", {31'd0, q_valid}, 32'd1);
    check("pend_Q", {24'd0, Q}, 32'h77);
    rst = 1'b1; req1 = 1'b1; i1 = 8'h99;
    @(posedge clk); #1;
    check("mid_rst_gnt0", {31'd0, gnt0}, 32'd0);
    check("mid_rst_gnt1", {31'd0, gnt1}, 32'd0);
    check("mid_rst_s", {31'd0, s}, 32'd0);
    check("mid_rst_q_valid", {31'd0, q_valid}, 32'd0);
    check("mid_rst_Q", {24'd0, Q}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("tie_after_rst_gnt0", {31'd0, gnt0}, 32'd1);
    check("tie_after_rst_gnt1", {31'd0, gnt1}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
